// File: rtl/dma_desc_pkg.sv
// Shared types and descriptor layout for the DMA descriptor fetcher.
package dma_desc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_FETCH_SRC  = 4'd1,
    ST_FETCH_DST  = 4'd2,
    ST_FETCH_CTRL = 4'd3,
    ST_CHECK      = 4'd4,
    ST_ISSUE      = 4'd5,
    ST_WAIT_DONE  = 4'd6,
    ST_NEXT       = 4'd7,
    ST_FINISH     = 4'd8
  } state_e;

  // Word offsets inside one descriptor and the distance between descriptors.
  localparam int OFS_SRC     = 0;
  localparam int OFS_DST     = 1;
  localparam int OFS_CTRL    = 2;
  localparam int DESC_STRIDE = 3;

  // Bit positions inside the ctrl word.
  localparam int CTRL_VALID = 0;
  localparam int CTRL_LAST  = 1;

endpackage

// File: rtl/dma_watchdog.sv
// Cycle watchdog for the WAIT_DONE state: load clears, enable counts, expire flags
// the LIMIT-th enabled cycle. Only instantiated when DESC_TIMEOUT_EN is defined.
module dma_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = enable && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/dma_desc_fetcher.sv
// Walks a descriptor list in memory and feeds src/dst pairs to the DMA address generator.
// Optional build macro DESC_TIMEOUT_EN adds a watchdog on the generator's done pulse.
//
// Handshakes: mem_req_o/mem_addr_o stay asserted and stable until the cycle mem_rvalid_i
// is high (that cycle completes the read, rvalid may coincide with the first req cycle);
// ag_start_o is a single-cycle pulse and ag_done_i is only honoured in WAIT_DONE.
module dma_desc_fetcher
  import dma_desc_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_DESC       = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  ag_start_o,
  output logic [ADDR_WIDTH-1:0] ag_src_o,
  output logic [ADDR_WIDTH-1:0] ag_dst_o,
  input  logic                  ag_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [3:0]            desc_count_o,
  output state_e                dbg_state
);

  // Index register is 4 bits wide; MAX_DESC must not exceed 16.
  localparam logic [3:0] LAST_IDX = 4'(MAX_DESC - 1);

  state_e                state, state_n;
  logic [3:0]            idx;
  logic [ADDR_WIDTH-1:0] desc_base;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic                  ctrl_valid_q, ctrl_last_q;

  logic accept, cap_src, cap_dst, cap_ctrl, load_ag, set_err, inc_count, advance;
  logic wd_load, wd_enable, wd_expire;

`ifdef DESC_TIMEOUT_EN
  dma_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load    (wd_load),
    .enable  (wd_enable),
    .expire  (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    cap_src   = 1'b0;
    cap_dst   = 1'b0;
    cap_ctrl  = 1'b0;
    load_ag   = 1'b0;
    set_err   = 1'b0;
    inc_count = 1'b0;
    advance   = 1'b0;
    wd_load   = 1'b0;
    wd_enable = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_n = ST_FETCH_SRC;
        end
      end
      ST_FETCH_SRC: begin
        if (mem_rvalid_i) begin
          cap_src = 1'b1;
          state_n = ST_FETCH_DST;
        end
      end
      ST_FETCH_DST: begin
        if (mem_rvalid_i) begin
          cap_dst = 1'b1;
          state_n = ST_FETCH_CTRL;
        end
      end
      ST_FETCH_CTRL: begin
        if (mem_rvalid_i) begin
          cap_ctrl = 1'b1;
          state_n  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!ctrl_valid_q) begin
          set_err = 1'b1;
          state_n = ST_FINISH;
        end else begin
          load_ag = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_load = 1'b1;
        state_n = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        wd_enable = 1'b1;
        // A done pulse in the expiry cycle still counts as a normal completion.
        if (ag_done_i) begin
          state_n = ST_NEXT;
        end else if (wd_expire) begin
          set_err = 1'b1;
          state_n = ST_FINISH;
        end
      end
      ST_NEXT: begin
        inc_count = 1'b1;
        if (ctrl_last_q || (idx == LAST_IDX)) begin
          state_n = ST_FINISH;
        end else begin
          advance = 1'b1;
          state_n = ST_FETCH_SRC;
        end
      end
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx          <= '0;
      desc_base    <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      ctrl_valid_q <= 1'b0;
      ctrl_last_q  <= 1'b0;
      ag_src_o     <= '0;
      ag_dst_o     <= '0;
      err_o        <= 1'b0;
      desc_count_o <= '0;
    end else begin
      if (accept) begin
        idx          <= '0;
        desc_base    <= base_addr_i;
        err_o        <= 1'b0;
        desc_count_o <= '0;
      end
      if (cap_src)  src_q <= mem_rdata_i[ADDR_WIDTH-1:0];
      if (cap_dst)  dst_q <= mem_rdata_i[ADDR_WIDTH-1:0];
      if (cap_ctrl) begin
        ctrl_valid_q <= mem_rdata_i[CTRL_VALID];
        ctrl_last_q  <= mem_rdata_i[CTRL_LAST];
      end
      // Downstream addresses change only when a new descriptor is issued.
      if (load_ag) begin
        ag_src_o <= src_q;
        ag_dst_o <= dst_q;
      end
      if (set_err) err_o <= 1'b1;
      if (inc_count && (desc_count_o != 4'hF)) desc_count_o <= desc_count_o + 4'd1;
      if (advance) begin
        idx       <= idx + 4'd1;
        desc_base <= desc_base + ADDR_WIDTH'(DESC_STRIDE);
      end
    end
  end

  // Read address is the descriptor base plus the word offset; sums wrap at ADDR_WIDTH.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    unique case (state)
      ST_FETCH_SRC: begin
        mem_req_o  = 1'b1;
        mem_addr_o = desc_base + ADDR_WIDTH'(OFS_SRC);
      end
      ST_FETCH_DST: begin
        mem_req_o  = 1'b1;
        mem_addr_o = desc_base + ADDR_WIDTH'(OFS_DST);
      end
      ST_FETCH_CTRL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = desc_base + ADDR_WIDTH'(OFS_CTRL);
      end
      default: begin
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
      end
    endcase
  end

  assign ag_start_o = (state == ST_ISSUE);
  assign done_o     = (state == ST_FINISH);
  assign busy_o     = (state != ST_IDLE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_dma_desc_fetcher.sv
// Directed bench for dma_desc_fetcher with a behavioural memory and address-generator model.
module tb_dma_desc_fetcher;
  import dma_desc_pkg::*;

  logic        clk_i, reset_i, start_i;
  logic [15:0] base_addr_i;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [15:0] mem_rdata_i;
  logic        ag_start_o;
  logic [15:0] ag_src_o, ag_dst_o;
  logic        ag_done_i;
  logic        busy_o, done_o, err_o;
  logic [3:0]  desc_count_o;
  state_e      dbg_state;

  dma_desc_fetcher dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .ag_start_o   (ag_start_o),
    .ag_src_o     (ag_src_o),
    .ag_dst_o     (ag_dst_o),
    .ag_done_i    (ag_done_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .desc_count_o (desc_count_o),
    .dbg_state    (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] exp_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] src_log[$];
  logic [15:0] dst_log[$];
  int          mem_delay    = 0;
  int          wait_cnt     = 0;
  int          gen_delay    = 0;
  int          gen_cnt      = 0;
  bit          gen_withhold = 0;
  int          starts       = 0;
  int          done_cnt     = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- memory responder ----------------
  initial begin
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      if (mem_req_o && !reset_i) begin
        if (wait_cnt >= mem_delay) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem[mem_addr_o];
          rd_q.push_back(mem_addr_o);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- address generator model ----------------
  initial begin
    ag_done_i = 1'b0;
    forever begin
      @(negedge clk_i);
      ag_done_i = 1'b0;
      if (reset_i) begin
        gen_cnt = 0;
      end else if (ag_start_o) begin
        starts++;
        src_log.push_back(ag_src_o);
        dst_log.push_back(ag_dst_o);
        if (!gen_withhold) gen_cnt = gen_delay + 1;
      end else if (gen_cnt > 0) begin
        gen_cnt--;
        if (gen_cnt == 0) ag_done_i = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (done_o) done_cnt++;
    end
  end

  // ---------------- driver / scoreboard tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    exp_q.delete();
    rd_q.delete();
    src_log.delete();
    dst_log.delete();
    starts   = 0;
    done_cnt = 0;
    wait_cnt = 0;
  endtask

  task automatic start_run(input logic [15:0] base);
    @(negedge clk_i);
    base_addr_i = base;
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i     = 1'b0;
  endtask

  task automatic wait_run_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    check("run_done_seen", 32'(ok), 32'd1);
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_nreads"}, 32'(rd_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rd_q.size() > 0)
      check({tag, "_rd_addr"}, 32'(rd_q.pop_front()), 32'(exp_q.pop_front()));
  endtask

  task automatic put_desc(input logic [15:0] a, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] c);
    mem[a]         = s;
    mem[a + 16'd1] = d;
    mem[a + 16'd2] = c;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_i     = 1'b1;
    start_i     = 1'b0;
    base_addr_i = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    repeat (3) @(negedge clk_i);

    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_count", 32'(desc_count_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_ag_start", 32'(ag_start_o), 32'd0);
    check("rst_ag_src", 32'(ag_src_o), 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Single descriptor, zero-wait memory.
    clear_logs();
    mem_delay = 0;
    put_desc(16'h0100, 16'h1000, 16'h2000, 16'h0003);
    for (int i = 0; i < 3; i++) exp_q.push_back(16'h0100 + 16'(i));
    start_run(16'h0100);
    check("t1_busy_after_start", 32'(busy_o), 32'd1);
    wait_run_done(100);
    check("t1_count", 32'(desc_count_o), 32'd1);
    check("t1_err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    check("t1_busy_low", 32'(busy_o), 32'd0);
    check("t1_done_pulses", 32'(done_cnt), 32'd1);
    check("t1_starts", 32'(starts), 32'd1);
    check("t1_src", 32'(src_log[0]), 32'h1000);
    check("t1_dst", 32'(dst_log[0]), 32'h2000);
    check("t1_src_held", 32'(ag_src_o), 32'h1000);
    check_reads("t1");

    // Three descriptors, LAST on the third, two-cycle memory latency.
    clear_logs();
    mem_delay = 2;
    put_desc(16'h0100, 16'h1111, 16'h2222, 16'h0001);
    put_desc(16'h0103, 16'h3333, 16'h4444, 16'h0001);
    put_desc(16'h0106, 16'h5555, 16'h6666, 16'h0003);
    for (int i = 0; i < 9; i++) exp_q.push_back(16'h0100 + 16'(i));
    start_run(16'h0100);
    wait_run_done(300);
    check("t2_count", 32'(desc_count_o), 32'd3);
    check("t2_err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    check("t2_starts", 32'(starts), 32'd3);
    check("t2_src2", 32'(src_log[2]), 32'h5555);
    check("t2_dst1", 32'(dst_log[1]), 32'h4444);
    check_reads("t2");

    // Second descriptor not VALID: one issue, then error.
    clear_logs();
    mem_delay = 1;
    put_desc(16'h0200, 16'h0A0A, 16'h0B0B, 16'h0001);
    put_desc(16'h0203, 16'h0C0C, 16'h0D0D, 16'h0000);
    start_run(16'h0200);
    wait_run_done(200);
    check("t3_err", 32'(err_o), 32'd1);
    check("t3_count", 32'(desc_count_o), 32'd1);
    @(negedge clk_i);
    check("t3_starts", 32'(starts), 32'd1);
    check("t3_nreads", 32'(rd_q.size()), 32'd6);
    check("t3_src_kept", 32'(ag_src_o), 32'h0A0A);

    // Address wrap at the top of memory; the accepted start clears the sticky error.
    clear_logs();
    mem_delay = 0;
    mem[16'hFFFE] = 16'h0AAA;
    mem[16'hFFFF] = 16'h0BBB;
    mem[16'h0000] = 16'h0003;
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    start_run(16'hFFFE);
    check("t4_err_cleared", 32'(err_o), 32'd0);
    wait_run_done(100);
    check("t4_count", 32'(desc_count_o), 32'd1);
    @(negedge clk_i);
    check("t4_src", 32'(src_log[0]), 32'h0AAA);
    check("t4_dst", 32'(dst_log[0]), 32'h0BBB);
    check_reads("t4");

    // MAX_DESC cap with no LAST, plus a start pulse in the middle of the run.
    clear_logs();
    mem_delay = 0;
    for (int k = 0; k < 9; k++)
      put_desc(16'h0300 + 16'(3 * k), 16'h1000 + 16'(k), 16'h2000 + 16'(k), 16'h0001);
    for (int i = 0; i < 24; i++) exp_q.push_back(16'h0300 + 16'(i));
    start_run(16'h0300);
    repeat (10) @(negedge clk_i);
    start_i     = 1'b1;
    base_addr_i = 16'h0500;
    @(negedge clk_i);
    start_i     = 1'b0;
    wait_run_done(400);
    check("t5_count", 32'(desc_count_o), 32'd8);
    check("t5_err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    check("t5_starts", 32'(starts), 32'd8);
    check("t5_last_src", 32'(ag_src_o), 32'h1007);
    check("t5_idle", 32'(dbg_state), 32'(ST_IDLE));
    check_reads("t5");

`ifdef DESC_TIMEOUT_EN
    // Generator never answers: watchdog ends the run after 64 WAIT_DONE cycles.
    begin
      int wait_cycles;
      wait_cycles = 0;
      clear_logs();
      gen_withhold = 1'b1;
      put_desc(16'h0100, 16'h1000, 16'h2000, 16'h0003);
      start_run(16'h0100);
      for (int i = 0; i < 400; i++) begin
        if (done_o) break;
        if (dbg_state == ST_WAIT_DONE) wait_cycles++;
        @(negedge clk_i);
      end
      check("to_done", 32'(done_o), 32'd1);
      check("to_wait_cycles", 32'(wait_cycles), 32'd64);
      check("to_err", 32'(err_o), 32'd1);
      check("to_count", 32'(desc_count_o), 32'd0);
      gen_withhold = 1'b0;
      @(negedge clk_i);
    end
`endif

    // Asynchronous reset while waiting for the generator.
    begin
      bit seen;
      seen = 1'b0;
      clear_logs();
      gen_withhold = 1'b1;
      put_desc(16'h0100, 16'h1000, 16'h2000, 16'h0003);
      start_run(16'h0100);
      for (int i = 0; i < 100; i++) begin
        if (ag_start_o) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk_i);
      end
      check("t6_issue_seen", 32'(seen), 32'd1);
      @(negedge clk_i);
      check("t6_in_wait", 32'(dbg_state), 32'(ST_WAIT_DONE));
      #2 reset_i = 1'b1;
      #1;
      check("t6_rst_busy", 32'(busy_o), 32'd0);
      check("t6_rst_src", 32'(ag_src_o), 32'd0);
      check("t6_rst_dst", 32'(ag_dst_o), 32'd0);
      check("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("t6_rst_req", 32'(mem_req_o), 32'd0);
      check("t6_rst_done", 32'(done_o), 32'd0);
      gen_withhold = 1'b0;
      @(negedge clk_i);
      reset_i = 1'b0;
      repeat (2) @(negedge clk_i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
